control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multicycle FSM that drives every crtl_* select and write-enable of the CPU datapath.
- Consumes the opcode/funct fields from the instruction register and the ULA status flags.
- Revision 1 sequences fetch, decode, an integer subset (add, sub, and, jr, addi, lw, sw, beq, bne, j, jal) and two exceptions (invalid opcode, overflow).
- Shifter, hi/lo and div controls are not produced in this revision; they stay tied 0 in the datapath.

Parameters:
- MEM_WAIT, 1: idle cycles between presenting a memory address and capturing its data (range 1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- ula_overflow  in  1  ULA overflow flag, combinational.
- ula_eq  in  1  ULA A==B flag, combinational.
- crtl_pcwrite  out  1  PC load enable.
- crtl_pcsource  out  3  000 ULA result, 001 EPC, 010 ALUOut, 011 A, 100 jump target, 101 load_size out.
- crtl_iord  out  2  memory address: 00 PC, 01 error vector, 10 ALUOut.
- crtl_error  out  2  vector select: 00 invalid opcode (253), 01 overflow (254).
- crtl_memwrite  out  1  memory write.
- crtl_ss  out  2  store size; 00 word.
- crtl_ls  out  2  load size: 00 word, 10 byte.
- crtl_irwrite  out  1  IR load.
- crtl_memDataRegWrite  out  1  MDR load.
- crtl_rega, crtl_regb, crtl_regaluout, crtl_regepc  out  1 each  register load enables.
- crtl_regwrite  out  1  register-bank write.
- crtl_regdst  out  3  000 rt, 001 rd, 010 constant 31.
- crtl_memtoreg  out  4  0001 ALUOut, 1000 PC, 1001 load_size out.
- crtl_ulasrca  out  1  0 PC, 1 A.
- crtl_ulasrcb  out  2  00 B, 01 constant 4, 10 sign-ext, 11 sign-ext<<2.
- crtl_ula  out  3  001 add, 010 sub, 011 and, 111 compare.

Behaviour:
- Reset and output decode:
  - rst asserted: state=RESET, wait counter=0, every output 0, independent of clk.
  - Outputs are a Moore decode of state. Exceptions: crtl_pcwrite in BRANCH depends on ula_eq; the EXEC/EXEC_I next-state depends on ula_overflow.
  - Any output not listed for a state is 0.
- Wait counter: in each *_WAIT state it counts MEM_WAIT cycles; the state advances when the count reaches MEM_WAIT-1, and the counter clears on exit.
- RESET -> FETCH0 on the first clk edge after rst deasserts.
- Fetch:
  - FETCH0/FETCH_WAIT/FETCH2: iord=00; ULA computes PC+4 (srca 0, srcb 01, ula 001).
  - FETCH2 additionally asserts irwrite and pcwrite with pcsource 000.
  - Fetch takes MEM_WAIT+2 cycles.
- DECODE: rega, regb; ALUOut <= PC + (sext<<2) (srca 0, srcb 11, ula 001, regaluout).
- Dispatch from DECODE:
  - opcode 0x00 with funct 0x20/0x22/0x24 -> EXEC; funct 0x08 -> JR.
  - opcode 0x08 -> EXEC_I; 0x23/0x2B -> ADDR; 0x04/0x05 -> BRANCH; 0x02 -> J; 0x03 -> JAL.
  - Any other opcode/funct -> EXC0 with error=00.
- R-type:
  - EXEC: srca 1, srcb 00, ula add/sub/and, regaluout.
  - ula_overflow=1 on add/sub -> EXC0 with error=01; otherwise WB_R.
  - and never raises an exception.
  - WB_R: regdst 001, memtoreg 0001, regwrite -> FETCH0.
- JR: pcwrite, pcsource 011 -> FETCH0.
- addi:
  - EXEC_I: srca 1, srcb 10, ula 001, regaluout; overflow -> EXC0 (error 01); else WB_I.
  - WB_I: regdst 000, memtoreg 0001, regwrite.
- Loads and stores:
  - ADDR: srca 1, srcb 10, ula 001, regaluout; lw -> MEM0, sw -> SW.
  - MEM0/MEM_WAIT: iord 10. MEM2: iord 10, memDataRegWrite. WB_LW: ls 00, memtoreg 1001, regdst 000, regwrite.
  - SW: iord 10, ss 00, memwrite, one cycle.
- BRANCH: srca 1, srcb 00, ula 111; pcwrite=(ula_eq for beq, !ula_eq for bne), pcsource 010 -> FETCH0.
- J: pcwrite, pcsource 100.
- JAL: in one cycle, regdst 010, memtoreg 1000, regwrite, pcwrite, pcsource 100. Both writes use the already-incremented PC.
- Exception sequence:
  - EXC0: srca 0, srcb 01, ula 010, regepc (EPC=PC-4); iord 01; error held.
  - EXC_WAIT: iord 01, error held.
  - EXC2: iord 01, memDataRegWrite.
  - EXC3: ls 10, pcsource 101, pcwrite -> FETCH0.
- Faulting instruction never writes the register bank; regwrite stays 0 from EXEC to EXC3.
- rst mid-instruction aborts immediately; no partial write is asserted on the cycle rst is high.

Test Plan:
- Reset held 3 cycles, released -> all outputs 0 during reset; FETCH0 on the first edge after release, irwrite pulses in cycle 3 (MEM_WAIT=1).
- add $3,$1,$2 with no overflow -> 6 cycles FETCH0..WB_R; exactly one regwrite, with regdst 001 and memtoreg 0001.
- add with ula_overflow=1 in EXEC -> EXC0 with error=01 and regepc=1; pcwrite with pcsource 101 after 4 exception cycles; regwrite never asserted.
- beq with ula_eq=1 -> pcwrite=1, pcsource=010 in BRANCH; with ula_eq=0 -> pcwrite=0; bne gives the inverse.
- opcode 0x3F -> EXC0 with error=00; lw at MEM_WAIT=3 -> MEM_WAIT holds 3 cycles, memDataRegWrite asserted exactly once.
- jal -> one cycle with regwrite, regdst 010, memtoreg 1000 and pcwrite, pcsource 100 together; rst pulsed during MEM_WAIT -> outputs 0 asynchronously, restart at FETCH0.

Source files
------------

// File: rtl/control_unit.sv
// Multicycle control FSM: sequences fetch, decode, the integer subset and the
// invalid-opcode / overflow exception path, driving every datapath control.
module control_unit #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       ula_overflow,
    input  logic       ula_eq,
    output logic       crtl_pcwrite,
    output logic [2:0] crtl_pcsource,
    output logic [1:0] crtl_iord,
    output logic [1:0] crtl_error,
    output logic       crtl_memwrite,
    output logic [1:0] crtl_ss,
    output logic [1:0] crtl_ls,
    output logic       crtl_irwrite,
    output logic       crtl_memDataRegWrite,
    output logic       crtl_rega,
    output logic       crtl_regb,
    output logic       crtl_regaluout,
    output logic       crtl_regepc,
    output logic       crtl_regwrite,
    output logic [2:0] crtl_regdst,
    output logic [3:0] crtl_memtoreg,
    output logic       crtl_ulasrca,
    output logic [1:0] crtl_ulasrcb,
    output logic [2:0] crtl_ula
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [4:0] {
        S_RESET, S_FETCH0, S_FETCH_WAIT, S_FETCH2, S_DECODE,
        S_EXEC, S_WB_R, S_JR, S_EXEC_I, S_WB_I,
        S_ADDR, S_MEM0, S_MEM_WAIT, S_MEM2, S_WB_LW, S_SW,
        S_BRANCH, S_J, S_JAL,
        S_EXC0, S_EXC_WAIT, S_EXC2, S_EXC3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       err_q, err_d;
    logic             wait_done;

    assign wait_done = (cnt_q == CNT_W'(MEM_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        cnt_d                = '0;
        err_d                = err_q;
        crtl_pcwrite         = 1'b0;
        crtl_pcsource        = 3'b000;
        crtl_iord            = 2'b00;
        crtl_error           = 2'b00;
        crtl_memwrite        = 1'b0;
        crtl_ss              = 2'b00;
        crtl_ls              = 2'b00;
        crtl_irwrite         = 1'b0;
        crtl_memDataRegWrite = 1'b0;
        crtl_rega            = 1'b0;
        crtl_regb            = 1'b0;
        crtl_regaluout       = 1'b0;
        crtl_regepc          = 1'b0;
        crtl_regwrite        = 1'b0;
        crtl_regdst          = 3'b000;
        crtl_memtoreg        = 4'b0000;
        crtl_ulasrca         = 1'b0;
        crtl_ulasrcb         = 2'b00;
        crtl_ula             = 3'b000;

        case (state_q)
            S_RESET: state_d = S_FETCH0;
            S_FETCH0, S_FETCH_WAIT, S_FETCH2: begin
                crtl_ulasrcb = 2'b01;
                crtl_ula     = 3'b001;
                if (state_q == S_FETCH0) begin
                    state_d = S_FETCH_WAIT;
                end else if (state_q == S_FETCH_WAIT) begin
                    if (wait_done) state_d = S_FETCH2;
                    else           cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    crtl_irwrite = 1'b1;
                    crtl_pcwrite = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                crtl_rega      = 1'b1;
                crtl_regb      = 1'b1;
                crtl_regaluout = 1'b1;
                crtl_ulasrcb   = 2'b11;
                crtl_ula       = 3'b001;
                // Anything not recognised here takes the invalid-opcode trap.
                state_d        = S_EXC0;
                err_d          = 2'b00;
                case (opcode)
                    6'h00: begin
                        if (funct == 6'h20 || funct == 6'h22 || funct == 6'h24) state_d = S_EXEC;
                        else if (funct == 6'h08)                                 state_d = S_JR;
                    end
                    6'h08:        state_d = S_EXEC_I;
                    6'h23, 6'h2B: state_d = S_ADDR;
                    6'h04, 6'h05: state_d = S_BRANCH;
                    6'h02:        state_d = S_J;
                    6'h03:        state_d = S_JAL;
                    default:      state_d = S_EXC0;
                endcase
            end
            S_EXEC: begin
                crtl_ulasrca   = 1'b1;
                crtl_regaluout = 1'b1;
                case (funct)
                    6'h22:   crtl_ula = 3'b010;
                    6'h24:   crtl_ula = 3'b011;
                    default: crtl_ula = 3'b001;
                endcase
                if (ula_overflow && funct != 6'h24) begin
                    state_d = S_EXC0;
                    err_d   = 2'b01;
                end else begin
                    state_d = S_WB_R;
                end
            end
            S_WB_R: begin
                crtl_regdst   = 3'b001;
                crtl_memtoreg = 4'b0001;
                crtl_regwrite = 1'b1;
                state_d       = S_FETCH0;
            end
            S_JR: begin
                crtl_pcwrite  = 1'b1;
                crtl_pcsource = 3'b011;
                state_d       = S_FETCH0;
            end
            S_EXEC_I, S_ADDR: begin
                crtl_ulasrca   = 1'b1;
                crtl_ulasrcb   = 2'b10;
                crtl_ula       = 3'b001;
                crtl_regaluout = 1'b1;
                if (state_q == S_ADDR) begin
                    state_d = (opcode == 6'h2B) ? S_SW : S_MEM0;
                end else if (ula_overflow) begin
                    state_d = S_EXC0;
                    err_d   = 2'b01;
                end else begin
                    state_d = S_WB_I;
                end
            end
            S_WB_I: begin
                crtl_memtoreg = 4'b0001;
                crtl_regwrite = 1'b1;
                state_d       = S_FETCH0;
            end
            S_MEM0: begin
                crtl_iord = 2'b10;
                state_d   = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                crtl_iord = 2'b10;
                if (wait_done) state_d = S_MEM2;
                else           cnt_d   = cnt_q + CNT_W'(1);
            end
            S_MEM2: begin
                crtl_iord            = 2'b10;
                crtl_memDataRegWrite = 1'b1;
                state_d              = S_WB_LW;
            end
            S_WB_LW: begin
                crtl_memtoreg = 4'b1001;
                crtl_regwrite = 1'b1;
                state_d       = S_FETCH0;
            end
            S_SW: begin
                crtl_iord     = 2'b10;
                crtl_memwrite = 1'b1;
                state_d       = S_FETCH0;
            end
            S_BRANCH: begin
                crtl_ulasrca  = 1'b1;
                crtl_ula      = 3'b111;
                crtl_pcsource = 3'b010;
                crtl_pcwrite  = (opcode == 6'h05) ? !ula_eq : ula_eq;
                state_d       = S_FETCH0;
            end
            S_J: begin
                crtl_pcwrite  = 1'b1;
                crtl_pcsource = 3'b100;
                state_d       = S_FETCH0;
            end
            S_JAL: begin
                crtl_regdst   = 3'b010;
                crtl_memtoreg = 4'b1000;
                crtl_regwrite = 1'b1;
                crtl_pcwrite  = 1'b1;
                crtl_pcsource = 3'b100;
                state_d       = S_FETCH0;
            end
            S_EXC0: begin
                crtl_ulasrcb = 2'b01;
                crtl_ula     = 3'b010;
                crtl_regepc  = 1'b1;
                crtl_iord    = 2'b01;
                crtl_error   = err_q;
                state_d      = S_EXC_WAIT;
            end
            S_EXC_WAIT: begin
                crtl_iord  = 2'b01;
                crtl_error = err_q;
                if (wait_done) state_d = S_EXC2;
                else           cnt_d   = cnt_q + CNT_W'(1);
            end
            S_EXC2: begin
                // Vector select stays valid through the capture cycle.
                crtl_iord            = 2'b01;
                crtl_error           = err_q;
                crtl_memDataRegWrite = 1'b1;
                state_d              = S_EXC3;
            end
            S_EXC3: begin
                crtl_ls       = 2'b10;
                crtl_pcsource = 3'b101;
                crtl_pcwrite  = 1'b1;
                state_d       = S_FETCH0;
            end
            default: state_d = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues the expected control word
// per cycle, a negedge monitor pops and compares it against the DUT.
module tb_control_unit;
    typedef struct packed {
        logic       pcwrite;
        logic [2:0] pcsource;
        logic [1:0] iord;
        logic [1:0] error;
        logic       memwrite;
        logic [1:0] ss;
        logic [1:0] ls;
        logic       irwrite;
        logic       mdrwrite;
        logic       rega;
        logic       regb;
        logic       regaluout;
        logic       regepc;
        logic       regwrite;
        logic [2:0] regdst;
        logic [3:0] memtoreg;
        logic       ulasrca;
        logic [1:0] ulasrcb;
        logic [2:0] ula;
    } cw_t;

    typedef struct {
        int    dut;
        cw_t   cw;
        string tag;
    } ent_t;

    localparam cw_t W_ZERO  = '0;
    localparam cw_t W_F0    = '{ulasrcb: 2'b01, ula: 3'b001, default: 0};
    localparam cw_t W_F2    = '{irwrite: 1'b1, pcwrite: 1'b1, ulasrcb: 2'b01, ula: 3'b001, default: 0};
    localparam cw_t W_DEC   = '{rega: 1'b1, regb: 1'b1, regaluout: 1'b1, ulasrcb: 2'b11, ula: 3'b001, default: 0};
    localparam cw_t W_ADD   = '{ulasrca: 1'b1, ula: 3'b001, regaluout: 1'b1, default: 0};
    localparam cw_t W_AND   = '{ulasrca: 1'b1, ula: 3'b011, regaluout: 1'b1, default: 0};
    localparam cw_t W_WBR   = '{regdst: 3'b001, memtoreg: 4'b0001, regwrite: 1'b1, default: 0};
    localparam cw_t W_IMM   = '{ulasrca: 1'b1, ulasrcb: 2'b10, ula: 3'b001, regaluout: 1'b1, default: 0};
    localparam cw_t W_WBI   = '{memtoreg: 4'b0001, regwrite: 1'b1, default: 0};
    localparam cw_t W_JR    = '{pcwrite: 1'b1, pcsource: 3'b011, default: 0};
    localparam cw_t W_BRT   = '{ulasrca: 1'b1, ula: 3'b111, pcwrite: 1'b1, pcsource: 3'b010, default: 0};
    localparam cw_t W_BRN   = '{ulasrca: 1'b1, ula: 3'b111, pcsource: 3'b010, default: 0};
    localparam cw_t W_J     = '{pcwrite: 1'b1, pcsource: 3'b100, default: 0};
    localparam cw_t W_JAL   = '{regdst: 3'b010, memtoreg: 4'b1000, regwrite: 1'b1, pcwrite: 1'b1, pcsource: 3'b100, default: 0};
    localparam cw_t W_MEM   = '{iord: 2'b10, default: 0};
    localparam cw_t W_MEM2  = '{iord: 2'b10, mdrwrite: 1'b1, default: 0};
    localparam cw_t W_WBLW  = '{memtoreg: 4'b1001, regwrite: 1'b1, default: 0};
    localparam cw_t W_SW    = '{iord: 2'b10, memwrite: 1'b1, default: 0};
    localparam cw_t W_E0INV = '{ulasrcb: 2'b01, ula: 3'b010, regepc: 1'b1, iord: 2'b01, error: 2'b00, default: 0};
    localparam cw_t W_E0OVF = '{ulasrcb: 2'b01, ula: 3'b010, regepc: 1'b1, iord: 2'b01, error: 2'b01, default: 0};
    localparam cw_t W_EWINV = '{iord: 2'b01, error: 2'b00, default: 0};
    localparam cw_t W_EWOVF = '{iord: 2'b01, error: 2'b01, default: 0};
    localparam cw_t W_E2INV = '{iord: 2'b01, error: 2'b00, mdrwrite: 1'b1, default: 0};
    localparam cw_t W_E2OVF = '{iord: 2'b01, error: 2'b01, mdrwrite: 1'b1, default: 0};
    localparam cw_t W_E3    = '{ls: 2'b10, pcsource: 3'b101, pcwrite: 1'b1, default: 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic [5:0] opcode [2];
    logic [5:0] funct [2];
    logic       ovf [2];
    logic       eq [2];
    cw_t        act [2];

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t sb_q[$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       pcwrite, memwrite, irwrite, mdrwrite, rega, regb, regaluout, regepc, regwrite, ulasrca;
        logic [2:0] pcsource, regdst, ula;
        logic [1:0] iord, error, ss, ls, ulasrcb;
        logic [3:0] memtoreg;

        control_unit #(.MEM_WAIT(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst(rst[g]), .opcode(opcode[g]), .funct(funct[g]),
            .ula_overflow(ovf[g]), .ula_eq(eq[g]),
            .crtl_pcwrite(pcwrite), .crtl_pcsource(pcsource), .crtl_iord(iord),
            .crtl_error(error), .crtl_memwrite(memwrite), .crtl_ss(ss), .crtl_ls(ls),
            .crtl_irwrite(irwrite), .crtl_memDataRegWrite(mdrwrite),
            .crtl_rega(rega), .crtl_regb(regb), .crtl_regaluout(regaluout),
            .crtl_regepc(regepc), .crtl_regwrite(regwrite), .crtl_regdst(regdst),
            .crtl_memtoreg(memtoreg), .crtl_ulasrca(ulasrca), .crtl_ulasrcb(ulasrcb),
            .crtl_ula(ula)
        );

        assign act[g] = {pcwrite, pcsource, iord, error, memwrite, ss, ls, irwrite, mdrwrite,
                         rega, regb, regaluout, regepc, regwrite, regdst, memtoreg,
                         ulasrca, ulasrcb, ula};
    end

    // Monitor: one expected control word per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            ent_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (act[e.dut] !== e.cw) begin
                n_errors++;
                $display("FAIL %s dut%0d: got %h expected %h", e.tag, e.dut, act[e.dut], e.cw);
            end
        end
    end

    task automatic exp(input int d, input cw_t w, input string tag);
        ent_t e;
        e.dut = d;
        e.cw  = w;
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int d, input logic [5:0] op, input logic [5:0] fn);
        opcode[d] = op;
        funct[d]  = fn;
        exp(d, W_F0, "fetch0");
        for (int i = 0; i < (d == 0 ? 1 : 3); i++) exp(d, W_F0, "fetch_wait");
        exp(d, W_F2, "fetch2");
        exp(d, W_DEC, "decode");
    endtask

    task automatic exc(input logic ovf_kind);
        exp(0, ovf_kind ? W_E0OVF : W_E0INV, "exc0");
        exp(0, ovf_kind ? W_EWOVF : W_EWINV, "exc_wait");
        exp(0, ovf_kind ? W_E2OVF : W_E2INV, "exc2");
        exp(0, W_E3, "exc3");
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; opcode[i] = '0; funct[i] = '0; ovf[i] = 1'b0; eq[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) exp(0, W_ZERO, "reset_hold");
        rst[0] = 1'b0;
        exp(0, W_ZERO, "reset_release");

        fetch(0, 6'h00, 6'h20);
        exp(0, W_ADD, "add_exec");
        exp(0, W_WBR, "add_wb");

        fetch(0, 6'h00, 6'h20);
        ovf[0] = 1'b1;
        exp(0, W_ADD, "add_ovf_exec");
        ovf[0] = 1'b0;
        exc(1'b1);

        fetch(0, 6'h00, 6'h24);
        ovf[0] = 1'b1;
        exp(0, W_AND, "and_ovf_exec");
        ovf[0] = 1'b0;
        exp(0, W_WBR, "and_wb");

        fetch(0, 6'h04, 6'h00);
        eq[0] = 1'b1;
        exp(0, W_BRT, "beq_eq1");
        fetch(0, 6'h04, 6'h00);
        eq[0] = 1'b0;
        exp(0, W_BRN, "beq_eq0");
        fetch(0, 6'h05, 6'h00);
        eq[0] = 1'b1;
        exp(0, W_BRN, "bne_eq1");
        fetch(0, 6'h05, 6'h00);
        eq[0] = 1'b0;
        exp(0, W_BRT, "bne_eq0");

        fetch(0, 6'h3F, 6'h00);
        exc(1'b0);

        fetch(0, 6'h03, 6'h00);
        exp(0, W_JAL, "jal");
        fetch(0, 6'h02, 6'h00);
        exp(0, W_J, "j");
        fetch(0, 6'h00, 6'h08);
        exp(0, W_JR, "jr");
        fetch(0, 6'h08, 6'h00);
        exp(0, W_IMM, "addi_exec");
        exp(0, W_WBI, "addi_wb");
        fetch(0, 6'h2B, 6'h00);
        exp(0, W_IMM, "sw_addr");
        exp(0, W_SW, "sw");

        // Reset pulsed in the fetch wait cycle must clear outputs at once.
        opcode[0] = 6'h00;
        exp(0, W_F0, "pre_rst_fetch0");
        begin
            ent_t e;
            e.dut = 0; e.cw = W_F0; e.tag = "pre_rst_wait";
            sb_q.push_back(e);
        end
        #6;
        rst[0] = 1'b1;
        #1;
        n_checks++;
        if (act[0] !== W_ZERO) begin
            n_errors++;
            $display("FAIL async_rst: got %h expected %h", act[0], W_ZERO);
        end
        @(posedge clk);
        #1;
        exp(0, W_ZERO, "rst_mid");
        rst[0] = 1'b0;
        exp(0, W_ZERO, "rst_mid_release");
        fetch(0, 6'h00, 6'h22);
        exp(0, '{ulasrca: 1'b1, ula: 3'b010, regaluout: 1'b1, default: 0}, "sub_exec");
        exp(0, W_WBR, "sub_wb");

        // Second instance, MEM_WAIT=3: lw with a three-cycle memory wait.
        rst[1] = 1'b0;
        exp(1, W_ZERO, "mw3_reset_release");
        fetch(1, 6'h23, 6'h00);
        exp(1, W_IMM, "lw_addr");
        exp(1, W_MEM, "lw_mem0");
        for (int i = 0; i < 3; i++) exp(1, W_MEM, "lw_mem_wait");
        exp(1, W_MEM2, "lw_mem2");
        exp(1, W_WBLW, "lw_wb");
        exp(1, W_F0, "lw_next_fetch0");

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
